// File: rtl/memAccess_pkg.sv
// Shared types and helpers for the load/store sequencer.
package memAccess_pkg;

  // Byte lanes per memory word.
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // True when the access cannot be issued: unaligned half/word or size code 3.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = addr_lo[0];
      2'd2:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: merges store data into a read word and extracts/extends load data.
module mem_lane_align
  import memAccess_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rd_word,
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] st_data,
  output logic [DATA_W-1:0] wr_word,
  output logic [DATA_W-1:0] ld_word
);

  logic [15:0] sh_lo;

  // Per byte lane: take store data when this lane is addressed, else keep the read byte.
  // Byte stores replicate data byte 0; halfword stores map data bytes 0/1 onto lanes 0/1 or 2/3.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [1:0] LANE = 2'(k);
    logic       hit;
    logic [7:0] byte_in;
    assign hit     = (size == BYTE) ? (addr_lo == LANE) :
                     (size == HALF) ? (addr_lo[1] == LANE[1]) : 1'b1;
    assign byte_in = (size == BYTE) ? st_data[7:0] :
                     (size == HALF) ? st_data[8*(k%2) +: 8] : st_data[8*k +: 8];
    assign wr_word[8*k +: 8] = hit ? byte_in : rd_word[8*k +: 8];
  end

  // Addressed lane moved down to bit 0; only the low halfword is ever needed.
  assign sh_lo = 16'(rd_word >> {addr_lo, 3'b000});

  // Sign- or zero-extend the extracted lane; word loads pass straight through.
  always_comb begin
    ld_word = rd_word;
    case (size)
      2'd0:    ld_word = {{(DATA_W-8){is_signed & sh_lo[7]}}, sh_lo[7:0]};
      2'd1:    ld_word = {{(DATA_W-16){is_signed & sh_lo[15]}}, sh_lo};
      default: ld_word = rd_word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer driving a word-wide memory with combinational read
// and edge write; sub-word stores are done as read-modify-write.
module mem_access_ctrl
  import memAccess_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [1:0]        reqSize,
  input  logic              reqSigned,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [DATA_W-1:0] reqWdata,
  output logic              respValid,
  output logic [DATA_W-1:0] respData,
  output logic              respErr,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata
);

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdWord_q, rdWord_d;
  logic                respValid_q, respValid_d;
  logic [DATA_W-1:0]   respData_q, respData_d;
  logic                respErr_q, respErr_d;

  logic [DATA_W-1:0]   align_rd, wr_word, ld_word;
  logic                mem_phase;

  // In READ the load result comes straight from memory so it can be registered
  // on the same edge that captures rdWord; in WRITE the captured word is merged.
  assign align_rd = (state_q == READ) ? memRdata : rdWord_q;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .rd_word   (align_rd),
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .is_signed (signed_q),
    .st_data   (wdata_q),
    .wr_word   (wr_word),
    .ld_word   (ld_word)
  );

  // Memory-side and handshake outputs are forced quiet while reset is held.
  assign reqReady  = resetN && (state_q == IDLE);
  assign mem_phase = resetN && ((state_q == READ) || (state_q == WRITE));
  assign memAddr   = mem_phase ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign memWe     = resetN && (state_q == WRITE);
  assign memWdata  = memWe ? wr_word : '0;

  assign respValid = respValid_q;
  assign respData  = respData_q;
  assign respErr   = respErr_q;

  // Next-state and next-register computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdWord_d    = rdWord_q;
    respValid_d = 1'b0;
    respData_d  = respData_q;
    respErr_d   = respErr_q;
    case (state_q)
      IDLE: begin
        if (reqValid && reqReady) begin
          write_d  = reqWrite;
          size_d   = reqSize;
          signed_d = reqSigned;
          addr_d   = reqAddr;
          wdata_d  = reqWdata;
          if (misaligned(reqSize, reqAddr[1:0])) begin
            state_d     = RESP;
            respValid_d = 1'b1;
            respErr_d   = 1'b1;
            respData_d  = '0;
          end else if (reqWrite && (reqSize == WORD)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        rdWord_d = memRdata;
        if (write_q) begin
          state_d = WRITE;
        end else begin
          state_d     = RESP;
          respValid_d = 1'b1;
          respErr_d   = 1'b0;
          respData_d  = ld_word;
        end
      end
      WRITE: begin
        state_d     = RESP;
        respValid_d = 1'b1;
        respErr_d   = 1'b0;
        respData_d  = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request/response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdWord_q    <= '0;
      respValid_q <= 1'b0;
      respData_q  <= '0;
      respErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdWord_q    <= rdWord_d;
      respValid_q <= respValid_d;
      respData_q  <= respData_d;
      respErr_q   <= respErr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small word memory model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        reqValid, reqReady, reqWrite, reqSigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic        respValid, respErr, memWe;
  logic [31:0] respData, memAddr, memWdata, memRdata;

  logic [31:0] mem [0:15] = '{default: 32'h0};
  int          we_cnt = 0;
  int          total = 0, passed = 0;
  int          base;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqWrite  (reqWrite),
    .reqSize   (reqSize),
    .reqSigned (reqSigned),
    .reqAddr   (reqAddr),
    .reqWdata  (reqWdata),
    .respValid (respValid),
    .respData  (respData),
    .respErr   (respErr),
    .memWe     (memWe),
    .memAddr   (memAddr),
    .memWdata  (memWdata),
    .memRdata  (memRdata)
  );

  assign memRdata = mem[memAddr[5:2]];

  always @(posedge clk) begin
    if (memWe === 1'b1) begin
      mem[memAddr[5:2]] <= memWdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request while IDLE, take it on the next edge, then scramble inputs.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    chk("ready_before_issue", reqReady, 1);
    reqValid = 1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqWdata = d;
    tick();
    reqValid = 0; reqWrite = ~w; reqSize = 2'd3; reqSigned = ~sg;
    reqAddr = 32'hFFFF_FFFF; reqWdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, sz, sg, a, 32'h0);
    chk({tag, "_lat1_rv"}, respValid, 0);
    chk({tag, "_lat1_we"}, memWe, 0);
    tick();
    chk({tag, "_rv"}, respValid, 1);
    chk({tag, "_err"}, respErr, 0);
    chk({tag, "_data"}, respData, exp);
    tick();
    chk({tag, "_pulse"}, respValid, 0);
  endtask

  initial begin
    resetN = 0; reqValid = 0; reqWrite = 0; reqSize = 0; reqSigned = 0;
    reqAddr = 0; reqWdata = 0;
    tick(); tick();
    chk("rst_ready", reqReady, 0);
    chk("rst_we", memWe, 0);
    chk("rst_rv", respValid, 0);
    chk("rst_rdata", respData, 0);
    chk("rst_err", respErr, 0);
    chk("rst_addr", memAddr, 0);
    chk("rst_wdata", memWdata, 0);
    resetN = 1;
    #1;
    chk("rst_rel_ready", reqReady, 1);

    // word store 0x20 to 0, then word load
    issue(1'b1, 2'd2, 1'b0, 32'h0, 32'h20);
    chk("ws_we", memWe, 1);
    chk("ws_addr", memAddr, 0);
    chk("ws_wdata", memWdata, 32'h20);
    chk("ws_rv0", respValid, 0);
    tick();
    chk("ws_rv", respValid, 1);
    chk("ws_rdata", respData, 0);
    chk("ws_we_off", memWe, 0);
    tick();
    chk("ws_mem", mem[0], 32'h20);
    do_load("lw0", 2'd2, 1'b0, 32'h0, 32'h20);

    // preload word 4 through a word store
    issue(1'b1, 2'd2, 1'b0, 32'h4, 32'h1122_3344);
    tick(); tick();
    chk("pre_mem", mem[1], 32'h1122_3344);

    // byte store 0xAB to address 6: READ, WRITE, RESP
    issue(1'b1, 2'd0, 1'b0, 32'h6, 32'h1234_56AB);
    chk("sb_read_we", memWe, 0);
    chk("sb_read_addr", memAddr, 32'h4);
    tick();
    chk("sb_write_we", memWe, 1);
    chk("sb_write_addr", memAddr, 32'h4);
    chk("sb_merge", memWdata, 32'h11AB_3344);
    chk("sb_rv0", respValid, 0);
    tick();
    chk("sb_rv", respValid, 1);
    chk("sb_rdata", respData, 0);
    tick();
    chk("sb_mem", mem[1], 32'h11AB_3344);

    do_load("lb_s6", 2'd0, 1'b1, 32'h6, 32'hFFFF_FFAB);
    do_load("lb_u6", 2'd0, 1'b0, 32'h6, 32'h0000_00AB);
    do_load("lh_s4", 2'd1, 1'b1, 32'h4, 32'h0000_3344);
    do_load("lb_s7", 2'd0, 1'b1, 32'h7, 32'h0000_0011);

    // halfword store 0x8001 to address 2 (upper lane of word 0)
    issue(1'b1, 2'd1, 1'b0, 32'h2, 32'hFFFF_8001);
    tick();
    chk("sh_merge", memWdata, 32'h8001_0020);
    tick(); tick();
    chk("sh_mem", mem[0], 32'h8001_0020);

    // alignment and illegal-size errors
    base = we_cnt;
    issue(1'b1, 2'd1, 1'b0, 32'h5, 32'h0000_BEEF);
    chk("e_sh5_rv", respValid, 1);
    chk("e_sh5_err", respErr, 1);
    chk("e_sh5_data", respData, 0);
    chk("e_sh5_we", memWe, 0);
    tick();
    chk("e_sh5_pulse", respValid, 0);
    chk("e_sh5_hold", respErr, 1);
    issue(1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
    chk("e_lw2_rv", respValid, 1);
    chk("e_lw2_err", respErr, 1);
    tick();
    issue(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    chk("e_sz3_err", respErr, 1);
    tick();
    chk("e_no_write", we_cnt - base, 0);
    chk("e_mem_same", mem[1], 32'h11AB_3344);

    do_load("lh_s2", 2'd1, 1'b1, 32'h2, 32'hFFFF_8001);

    // reset during the WRITE cycle of a byte store
    base = we_cnt;
    issue(1'b1, 2'd0, 1'b0, 32'h8, 32'h0000_00CD);
    tick();
    chk("rw_in_write", memWe, 1);
    resetN = 0;
    #1;
    chk("rw_we_gated", memWe, 0);
    tick();
    chk("rw_rv", respValid, 0);
    chk("rw_ready", reqReady, 0);
    chk("rw_rdata", respData, 0);
    resetN = 1;
    #1;
    chk("rw_ready_rel", reqReady, 1);
    chk("rw_no_write", we_cnt - base, 0);
    chk("rw_mem", mem[2], 0);
    tick();
    chk("rw_rv_after", respValid, 0);

    // three word stores with reqValid held continuously
    base = we_cnt;
    reqWrite = 1; reqSize = 2'd2; reqSigned = 0;
    for (int i = 0; i < 3; i++) begin
      chk("q_ready", reqReady, 1);
      reqValid = 1; reqAddr = 32'h10 + 32'(4 * i); reqWdata = 32'(i + 1);
      tick();
      if (i == 2) reqValid = 0;
      chk("q_busy1", reqReady, 0);
      chk("q_addr", memAddr, 32'h10 + 32'(4 * i));
      tick();
      chk("q_busy2", reqReady, 0);
      chk("q_rv", respValid, 1);
      tick();
    end
    tick(); tick();
    chk("q_we_count", we_cnt - base, 3);
    chk("q_mem4", mem[4], 32'h1);
    chk("q_mem5", mem[5], 32'h2);
    chk("q_mem6", mem[6], 32'h3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
